// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for UART transmit sequencing
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    localparam int unsigned MAX_REQ = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// rtl/rr_priority_sel.sv - round-robin winner select starting at a pointer
module rr_priority_sel
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] winner_o,
    output logic             valid_o
);

    int j;

    // Scan upward from ptr_i with wrap; the first set request wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        j        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!valid_o && req_i[j]) begin
                winner_o[j] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-locked round-robin sharing of one uart_tx
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int DATA_BITS     = 8,
    parameter int FRAME_TIMEOUT = 4096
) (
    input  logic                       clk_in,
    input  logic                       nrst_in,
    input  logic [N_REQ-1:0]           req_valid_in,
    input  logic [N_REQ*DATA_BITS-1:0] req_data_in,
    input  logic [N_REQ-1:0]           req_last_in,
    output logic [N_REQ-1:0]           req_ready_out,
    output logic [N_REQ-1:0]           grant_out,
    output logic                       tx_start_out,
    output logic [DATA_BITS-1:0]       tx_data_out,
    input  logic                       tx_busy_in,
    output logic                       frame_abort_out
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(FRAME_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 abort_q, abort_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_flag_q, last_flag_d;

    logic [IDX_W-1:0]     rr_ptr;
    logic [N_REQ-1:0]     sel_onehot;
    logic                 sel_valid;
    logic [IDX_W-1:0]     sel_idx;
    logic                 gnt_valid;
    logic                 gnt_last;
    logic [DATA_BITS-1:0] gnt_data;
    logic                 accept;
    logic                 timeout_hit;

    assign rr_ptr = (last_owner_q == IDX_W'(N_REQ - 1)) ? '0 : last_owner_q + 1'b1;

    rr_priority_sel #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_sel (
        .req_i    (req_valid_in),
        .ptr_i    (rr_ptr),
        .winner_o (sel_onehot),
        .valid_o  (sel_valid)
    );

    // Convert the one-hot winner into an index for the owner register.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign gnt_valid   = req_valid_in[owner_q];
    assign gnt_last    = req_last_in[owner_q];
    assign gnt_data    = req_data_in[owner_q*DATA_BITS +: DATA_BITS];
    assign accept      = (state_q == ST_LOAD) && gnt_valid && !tx_busy_in;
    assign timeout_hit = (state_q == ST_LOAD) && !gnt_valid &&
                         (cnt_q + 1'b1 == CNT_W'(FRAME_TIMEOUT));

    // State and datapath registers; reset abandons any frame silently.
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            abort_q      <= 1'b0;
            cnt_q        <= '0;
            last_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            abort_q      <= abort_d;
            cnt_q        <= cnt_d;
            last_flag_q  <= last_flag_d;
        end
    end

    // Next-state logic: the grant stays locked until the last byte or a timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (sel_valid) state_d = ST_LOAD;
            ST_LOAD: begin
                if (accept) begin
                    state_d = ST_WAIT_ACK;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ACK:  if (tx_busy_in) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy_in) state_d = last_flag_q ? ST_IDLE : ST_LOAD;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output/datapath updates; the counter only lives while in LOAD.
    always_comb begin
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        abort_d      = 1'b0;
        cnt_d        = '0;
        last_flag_d  = last_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_d = sel_onehot;
                    owner_d = sel_idx;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    tx_data_d   = gnt_data;
                    last_flag_d = gnt_last;
                    tx_start_d  = 1'b1;
                end else if (timeout_hit) begin
                    abort_d      = 1'b1;
                    grant_d      = '0;
                    last_owner_d = owner_q;
                end else begin
                    cnt_d = gnt_valid ? cnt_q : cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_in && last_flag_q) begin
                    grant_d      = '0;
                    last_owner_d = owner_q;
                    last_flag_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign req_ready_out   = accept ? grant_q : '0;
    assign grant_out       = grant_q;
    assign tx_start_out    = tx_start_q;
    assign tx_data_out     = tx_data_q;
    assign frame_abort_out = abort_q;

endmodule
